// File: rtl/apx_moa_pkg.sv
// Shared types and constant helpers for the approximate multi-operand adder.
package apx_moa_pkg;

    typedef enum logic {
        CELL_EXACT = 1'b0,
        CELL_APX   = 1'b1
    } cell_mode_e;

    function automatic int sum_w(input int width, input int n_ops);
        return width + $clog2(n_ops);
    endfunction

    function automatic int levels(input int n_ops);
        return $clog2(n_ops) - 1;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/apx_moa_if.sv
// Operand-set input stream and result output stream of the multi-operand adder.
interface apx_moa_if #(
    parameter int WIDTH = 8,
    parameter int N_OPS = 4
);
    localparam int SUM_W = apx_moa_pkg::sum_w(WIDTH, N_OPS);

    logic                     in_valid;
    logic                     in_ready;
    logic [N_OPS*WIDTH-1:0]   in_ops;
    logic                     out_valid;
    logic                     out_ready;
    logic [SUM_W-1:0]         out_sum;
    logic                     out_apx_err;

    modport master (
        output in_valid, in_ops, out_ready,
        input  in_ready, out_valid, out_sum, out_apx_err
    );

    modport slave (
        input  in_valid, in_ops, out_ready,
        output in_ready, out_valid, out_sum, out_apx_err
    );

endinterface

// File: rtl/apx_moa_cell.sv
// One column of a 4:2 compressor; MODE picks the exact or the approximate cell.
module apx_moa_cell
    import apx_moa_pkg::*;
#(
    parameter cell_mode_e MODE = CELL_EXACT
) (
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic x4,
    input  logic cin,
    output logic cout,
    output logic sum,
    output logic carry,
    output logic e
);

    if (MODE == CELL_APX) begin : g_apx
        // Counts 1111 as three; e flags that lost unit.
        logic unused_cin;
        assign unused_cin = cin;
        assign e     = x1 & x2 & x3 & x4;
        assign sum   = (x1 ^ x2 ^ x3 ^ x4) | e;
        assign carry = ((x1 ^ x2) & (x3 ^ x4)) | ((x1 & x2) ^ (x3 & x4)) | e;
        assign cout  = 1'b0;
    end else begin : g_exact
        logic s1;
        assign s1    = x1 ^ x2 ^ x3;
        assign cout  = maj3(x1, x2, x3);
        assign sum   = s1 ^ x4 ^ cin;
        assign carry = maj3(s1, x4, cin);
        assign e     = 1'b0;
    end

endmodule

// File: rtl/apx_moa_pipe.sv
// Pipelined N_OPS-operand adder: 4:2 compressor tree with approximate low columns.
// Define APX_MOA_ERR_CNT_EN to build the saturating approximation-event counter.
module apx_moa_pipe
    import apx_moa_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N_OPS     = 4,
    parameter int APX_BITS  = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    apx_moa_if.slave             bus,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int SUM_W  = sum_w(WIDTH, N_OPS);
    localparam int LEVELS = levels(N_OPS);
    localparam int NCMP   = N_OPS / 4;

    if (!(N_OPS == 4 || N_OPS == 8) || APX_BITS < 0 || APX_BITS > WIDTH || WIDTH < 2) begin : g_bad_cfg
        $error("apx_moa_pipe: unsupported WIDTH/N_OPS/APX_BITS combination");
    end

    logic [SUM_W-1:0]            rin_c  [LEVELS][N_OPS];
    logic [SUM_W-1:0]            srow_c [LEVELS][NCMP];
    logic [SUM_W-1:0]            crow_c [LEVELS][NCMP];
    logic [LEVELS-1:0][NCMP-1:0] e_c;

    logic [SUM_W-1:0]  row_p [LEVELS][N_OPS/2];
    logic [LEVELS-1:0] vld_p;
    logic [LEVELS-1:0] err_p;
    logic [SUM_W-1:0]  res_sum;
    logic              res_vld;
    logic              res_err;
    logic              adv;

    // Global stall: every stage moves together or not at all.
    assign adv             = !res_vld || bus.out_ready;
    assign bus.in_ready    = adv;
    assign bus.out_valid   = res_vld;
    assign bus.out_sum     = res_sum;
    assign bus.out_apx_err = res_err;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        for (genvar k = 0; k < N_OPS; k++) begin : g_rin
            if (l == 0) begin : g_src_in
                assign rin_c[l][k] = SUM_W'(bus.in_ops[k*WIDTH +: WIDTH]);
            end else if (k < (N_OPS >> l)) begin : g_src_reg
                assign rin_c[l][k] = row_p[l-1][k];
            end else begin : g_src_none
                assign rin_c[l][k] = '0;
            end
        end

        for (genvar j = 0; j < NCMP; j++) begin : g_cmp
            if (j < (N_OPS >> (l + 2))) begin : g_used
                logic [SUM_W:0]   cy;
                logic [SUM_W:0]   cr;
                logic [SUM_W-1:0] sv;
                logic [SUM_W-1:0] ev;
                logic             unused_msb;

                // Carry-out of the top column cannot be set: the full sum fits in SUM_W.
                assign cy[0]      = 1'b0;
                assign cr[0]      = 1'b0;
                assign unused_msb = cy[SUM_W] ^ cr[SUM_W];

                for (genvar c = 0; c < SUM_W; c++) begin : g_col
                    apx_moa_cell #(
                        .MODE((c < APX_BITS) ? CELL_APX : CELL_EXACT)
                    ) u_cell (
                        .x1   (rin_c[l][4*j][c]),
                        .x2   (rin_c[l][4*j+1][c]),
                        .x3   (rin_c[l][4*j+2][c]),
                        .x4   (rin_c[l][4*j+3][c]),
                        .cin  (cy[c]),
                        .cout (cy[c+1]),
                        .sum  (sv[c]),
                        .carry(cr[c+1]),
                        .e    (ev[c])
                    );
                end

                assign srow_c[l][j] = sv;
                assign crow_c[l][j] = cr[SUM_W-1:0];
                assign e_c[l][j]    = |ev;
            end else begin : g_idle
                assign srow_c[l][j] = '0;
                assign crow_c[l][j] = '0;
                assign e_c[l][j]    = 1'b0;
            end
        end
    end

    // ---- compressor level registers (data only, no reset) ----
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int l = 0; l < LEVELS; l++) begin
                for (int j = 0; j < NCMP; j++) begin
                    row_p[l][2*j]   <= srow_c[l][j];
                    row_p[l][2*j+1] <= crow_c[l][j];
                end
            end
        end
    end

    // ---- valid/error tags per level and carry-propagate adder stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p   <= '0;
            err_p   <= '0;
            res_vld <= 1'b0;
            res_err <= 1'b0;
            res_sum <= '0;
        end else if (adv) begin
            vld_p[0] <= bus.in_valid;
            err_p[0] <= |e_c[0];
            for (int l = 1; l < LEVELS; l++) begin
                vld_p[l] <= vld_p[l-1];
                err_p[l] <= err_p[l-1] | (|e_c[l]);
            end
            res_vld <= vld_p[LEVELS-1];
            res_err <= err_p[LEVELS-1];
            res_sum <= row_p[LEVELS-1][0] + row_p[LEVELS-1][1];
        end
    end

`ifdef APX_MOA_ERR_CNT_EN
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (err_clr) begin
            err_cnt_q <= '0;
        end else if (res_vld && bus.out_ready && res_err) begin
            err_cnt_q <= sat_inc(err_cnt_q);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_apx_moa_pipe.sv
// Self-checking bench: 4-operand approximate instance and 8-operand exact instance.
module tb_apx_moa_pipe;

    localparam int W       = 8;
    localparam int APX_A   = 4;
    localparam int CW_A    = 2;
    localparam int CNT_MAX = (1 << CW_A) - 1;
`ifdef APX_MOA_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        int sum;
        bit err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            err_clr_a = 1'b0;
    logic            err_clr_b = 1'b0;
    logic [CW_A-1:0] err_cnt_a;
    logic [15:0]     err_cnt_b;

    apx_moa_if #(.WIDTH(W), .N_OPS(4)) ia ();
    apx_moa_if #(.WIDTH(W), .N_OPS(8)) ib ();

    apx_moa_pipe #(.WIDTH(W), .N_OPS(4), .APX_BITS(APX_A), .ERR_CNT_W(CW_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia.slave), .err_clr(err_clr_a), .err_cnt(err_cnt_a)
    );

    apx_moa_pipe #(.WIDTH(W), .N_OPS(8), .APX_BITS(0), .ERR_CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib.slave), .err_clr(err_clr_b), .err_cnt(err_cnt_b)
    );

    always #5 clk = ~clk;

    int   nvec = 0;
    int   nerr = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   cnt_m = 0;
    bit   acc_a, fire_a, acc_b, fire_b;
    bit   hold_a = 1'b0;
    logic [9:0] hold_sum;
    logic       hold_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        nvec++;
        assert (obs === req) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, req);
        end
    endtask

    // Each low column whose four operand bits are all set loses one unit of its weight.
    function automatic exp_t model_a(input logic [4*W-1:0] ops);
        exp_t r;
        r.sum = 0;
        r.err = 1'b0;
        for (int k = 0; k < 4; k++) r.sum += int'(ops[k*W +: W]);
        for (int c = 0; c < APX_A; c++) begin
            if (ops[c] && ops[W+c] && ops[2*W+c] && ops[3*W+c]) begin
                r.sum -= (1 << c);
                r.err = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic exp_t model_b(input logic [8*W-1:0] ops);
        exp_t r;
        r.sum = 0;
        r.err = 1'b0;
        for (int k = 0; k < 8; k++) r.sum += int'(ops[k*W +: W]);
        return r;
    endfunction

    task automatic clear_model();
        qa.delete();
        qb.delete();
        cnt_m  = 0;
        hold_a = 1'b0;
    endtask

    // One clock: observe handshakes at the falling edge, then step past the rising edge.
    task automatic cyc();
        exp_t e;
        bit   e_err;
        @(negedge clk);
        acc_a  = ia.in_valid && ia.in_ready;
        fire_a = ia.out_valid && ia.out_ready;
        acc_b  = ib.in_valid && ib.in_ready;
        fire_b = ib.out_valid && ib.out_ready;
        if (hold_a) begin
            chk("a_hold_valid", ia.out_valid, 1);
            chk("a_hold_sum", ia.out_sum, hold_sum);
            chk("a_hold_err", ia.out_apx_err, hold_err);
        end
        chk("a_err_cnt", err_cnt_a, cnt_m);
        e_err = 1'b0;
        if (fire_a) begin
            if (qa.size() == 0) chk("a_unexpected_out", ia.out_valid, 0);
            else begin
                e = qa.pop_front();
                chk("a_sum", ia.out_sum, e.sum);
                chk("a_apx_err", ia.out_apx_err, e.err);
                e_err = e.err;
            end
        end
        if (acc_a) qa.push_back(model_a(ia.in_ops));
        hold_a   = ia.out_valid && !ia.out_ready;
        hold_sum = ia.out_sum;
        hold_err = ia.out_apx_err;
        if (CNT_EN) begin
            if (err_clr_a) cnt_m = 0;
            else if (fire_a && e_err && cnt_m < CNT_MAX) cnt_m++;
        end
        if (fire_b) begin
            if (qb.size() == 0) chk("b_unexpected_out", ib.out_valid, 0);
            else begin
                e = qb.pop_front();
                chk("b_sum", ib.out_sum, e.sum);
                chk("b_apx_err", ib.out_apx_err, e.err);
            end
        end
        if (acc_b) qb.push_back(model_b(ib.in_ops));
        @(posedge clk);
        #1;
    endtask

    task automatic directed_a(input string tag, input logic [7:0] op, input int req_sum, input bit req_err);
        int lat;
        ia.out_ready = 1'b1;
        ia.in_valid  = 1'b1;
        ia.in_ops    = {4{op}};
        cyc();
        chk({tag, "_accept"}, acc_a, 1);
        ia.in_valid = 1'b0;
        lat = 1;
        while (!ia.out_valid && lat < 10) begin
            cyc();
            lat++;
        end
        chk({tag, "_latency"}, lat, 2);
        chk({tag, "_sum"}, ia.out_sum, req_sum);
        chk({tag, "_apx_err"}, ia.out_apx_err, req_err);
        cyc();
    endtask

    initial begin
        int         lat;
        int         sent;
        int         nout;
        bit         seen;
        logic [7:0] m;

        ia.in_valid = 1'b0; ia.in_ops = '0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_ops = '0; ib.out_ready = 1'b0;
        clear_model();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_out_valid", ia.out_valid, 0);
        chk("rst_a_out_sum", ia.out_sum, 0);
        chk("rst_a_apx_err", ia.out_apx_err, 0);
        chk("rst_a_err_cnt", err_cnt_a, 0);
        chk("rst_b_out_valid", ib.out_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_a_in_ready", ia.in_ready, 1);
        chk("rst_b_in_ready", ib.in_ready, 1);

        // Directed corner values
        directed_a("ones01", 8'h01, 3, 1'b1);
        directed_a("ones0f", 8'h0F, 45, 1'b1);
        directed_a("onesf0", 8'hF0, 960, 1'b0);
        directed_a("zeros", 8'h00, 0, 1'b0);
        directed_a("onesff", 8'hFF, 1005, 1'b1);

        // Random operands with random valid/ready, biased toward shared low bits
        for (int t = 0; t < 400; t++) begin
            ia.in_valid  = ($urandom_range(3) != 0);
            ia.out_ready = ($urandom_range(3) != 0);
            ia.in_ops    = $urandom;
            if ($urandom_range(1) == 1) begin
                m = 8'($urandom_range(255));
                ia.in_ops |= {4{m}};
            end
            cyc();
        end
        ia.in_valid  = 1'b0;
        ia.out_ready = 1'b1;
        for (int t = 0; t < 10 && qa.size() > 0; t++) cyc();
        chk("a_rand_drain", qa.size(), 0);

        // Ten sets with out_ready pattern 1,0,0,1
        sent = 0;
        nout = 0;
        ia.in_valid = 1'b1;
        ia.in_ops   = $urandom;
        for (int t = 0; t < 200 && (sent < 10 || qa.size() > 0); t++) begin
            ia.out_ready = (t % 4 == 0) || (t % 4 == 3);
            cyc();
            if (fire_a) nout++;
            if (acc_a) begin
                sent++;
                if (sent == 10) ia.in_valid = 1'b0;
                else ia.in_ops = $urandom;
            end
        end
        chk("stream_sent", sent, 10);
        chk("stream_received", nout, 10);
        chk("stream_drain", qa.size(), 0);
        chk("stream_idle", ia.out_valid, 0);

        // Error counter saturation
        ia.out_ready = 1'b1;
        err_clr_a = 1'b1;
        cyc();
        err_clr_a = 1'b0;
        chk("cnt_cleared", err_cnt_a, 0);
        ia.in_valid = 1'b1;
        ia.in_ops   = {4{8'h01}};
        sent = 0;
        for (int t = 0; t < 20 && (sent < 5 || qa.size() > 0); t++) begin
            cyc();
            if (acc_a) begin
                sent++;
                if (sent == 5) ia.in_valid = 1'b0;
            end
        end
        chk("cnt_saturated", err_cnt_a, CNT_EN ? 3 : 0);

        // Clear concurrent with an erroring transfer
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b1;
        cyc();
        ia.in_valid = 1'b0;
        for (int t = 0; t < 10 && !ia.out_valid; t++) cyc();
        chk("clr_pending_valid", ia.out_valid, 1);
        chk("clr_pending_cnt", err_cnt_a, CNT_EN ? 3 : 0);
        ia.out_ready = 1'b1;
        err_clr_a = 1'b1;
        cyc();
        err_clr_a = 1'b0;
        chk("clr_transfer", fire_a, 1);
        chk("clr_wins", err_cnt_a, 0);

        // Reset with two sets in flight
        ia.in_valid = 1'b1;
        ia.in_ops   = {4{8'h0F}};
        cyc();
        ia.in_ops = {4{8'h01}};
        cyc();
        ia.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", ia.out_valid, 0);
        chk("mid_rst_err_cnt", err_cnt_a, 0);
        chk("mid_rst_apx_err", ia.out_apx_err, 0);
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", ia.in_ready, 1);
        for (int t = 0; t < 6; t++) begin
            cyc();
            chk("post_rst_no_stale", ia.out_valid, 0);
        end

        // Exact 8-operand instance: 1000 random sets, latency 3
        ib.out_ready = 1'b1;
        ib.in_valid  = 1'b1;
        ib.in_ops    = {$urandom, $urandom};
        sent = 0;
        lat  = 0;
        seen = 1'b0;
        for (int t = 0; t < 1200 && (sent < 1000 || qb.size() > 0); t++) begin
            cyc();
            if (acc_b) begin
                sent++;
                if (sent == 1000) ib.in_valid = 1'b0;
                else ib.in_ops = {$urandom, $urandom};
            end
            if (!seen) begin
                lat++;
                if (ib.out_valid) begin
                    seen = 1'b1;
                    chk("b_latency", lat, 3);
                end
            end
        end
        chk("b_first_out_seen", seen, 1);
        chk("b_sent", sent, 1000);
        chk("b_drain", qb.size(), 0);
        chk("b_err_cnt", err_cnt_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
